// File: rtl/output_handler.sv
// CPU-to-LED output path: latches a word on a CPU write and shows it one byte at a
// time (LSB first), stalling the CPU until each byte is confirmed with the button.
module output_handler #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        need_write,
  input  logic [31:0] write_data,
  input  logic [3:0]  bit_width,
  input  logic        button,
  output logic [7:0]  led_byte,
  output logic [1:0]  led_index,
  output logic        led_valid,
  output logic        stall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  state_t      state, state_nxt;
  logic        btn_p0, btn_p1;
  logic        db_lvl, db_lvl_q;
  logic [CNT_W-1:0] db_cnt;
  logic        press;
  logic [31:0] word_q, word_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [1:0]  last, last_nxt;
  logic        accept;
  logic        stall_raw;

  // Widths above four bytes saturate to the full word; returns the last byte index.
  function automatic logic [1:0] last_of(input logic [3:0] w);
    if (w > 4'd4) return 2'd3;
    else          return 2'(w - 4'd1);
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= button;
      btn_p1 <= btn_p0;
    end
  end

  // Debounce: level follows the synced input after a full stable window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_lvl   <= 1'b0;
      db_lvl_q <= 1'b0;
    end else begin
      db_lvl_q <= db_lvl;
      if (btn_p1 != db_lvl) begin
        if (db_cnt == CNT_MAX) begin
          db_lvl <= btn_p1;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press  = db_lvl & ~db_lvl_q;
  assign accept = (state == IDLE) & need_write & (bit_width != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      word_q <= '0;
      idx    <= '0;
      last   <= '0;
    end else begin
      state  <= state_nxt;
      word_q <= word_nxt;
      idx    <= idx_nxt;
      last   <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    idx_nxt   = idx;
    last_nxt  = last;
    stall_raw = 1'b0;
    led_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_raw = 1'b1;
          word_nxt  = write_data;
          last_nxt  = last_of(bit_width);
          idx_nxt   = 2'd0;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        stall_raw = 1'b1;
        led_valid = 1'b1;
        if (press) begin
          if (idx == last) state_nxt = DONE;
          else             idx_nxt   = idx + 2'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset must release the CPU even if a request is already pending.
  assign stall     = stall_raw & rst_n;
  assign led_index = idx;
  assign led_byte  = word_q[{idx, 3'b000} +: 8];

endmodule

// File: tb/tb_output_handler.sv
// Randomized scoreboard bench for output_handler with a short debounce window.
module tb_output_handler;

  localparam int DB = 4;

  logic        clk;
  logic        rst_n;
  logic        need_write;
  logic [31:0] write_data;
  logic [3:0]  bit_width;
  logic        button;
  logic [7:0]  led_byte;
  logic [1:0]  led_index;
  logic        led_valid;
  logic        stall;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] i;
  } exp_t;
  exp_t q[$];

  output_handler #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .need_write(need_write), .write_data(write_data),
    .bit_width(bit_width), .button(button), .led_byte(led_byte),
    .led_index(led_index), .led_valid(led_valid), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: a word of width w presents bytes 0..min(w,4)-1, LSB first.
  task automatic push_word(input logic [31:0] d, input int w);
    int nb;
    nb = (w > 4) ? 4 : w;
    for (int i = 0; i < nb; i++) begin
      exp_t e;
      e.b = 8'((d >> (8 * i)) & 32'hFF);
      e.i = 2'(i);
      q.push_back(e);
    end
  endtask

  // Monitor: every newly presented byte is popped and compared.
  logic       prev_valid = 1'b0;
  logic [1:0] prev_idx   = 2'd0;
  always @(negedge clk) begin
    exp_t e;
    if (led_valid) begin
      check("stall_in_show", stall, 1);
      if (!prev_valid || led_index != prev_idx) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte got=%0h idx=%0d want=none", led_byte, led_index);
        end else begin
          e = q.pop_front();
          check("led_byte", led_byte, e.b);
          check("led_index", led_index, e.i);
        end
      end
    end
    prev_valid <= led_valid;
    prev_idx   <= led_index;
  end

  task automatic start_word(input logic [31:0] d, input int w);
    write_data = d;
    bit_width  = 4'(w);
    need_write = 1'b1;
    #1;
    check("accept_stall", stall, (w != 0));
    if (w != 0) push_word(d, w);
    tick;
    if (w == 0) begin
      check("noop_stall", stall, 0);
      check("noop_valid", led_valid, 0);
      need_write = 1'b0;
    end else begin
      check("show_valid", led_valid, 1);
    end
  endtask

  task automatic show_word(input logic [31:0] d, input int w, input int presses,
                           input bit chain, input logic [31:0] nd, input int nw,
                           input bit bounce, input bit long_hold);
    int nb;
    bit seen;
    bit last_p;
    nb = (w > 4) ? 4 : w;
    for (int i = 0; i < presses; i++) begin
      last_p = (i == nb - 1);
      if (bounce && i == 0) begin
        button = 1'b1; tick;
        button = 1'b0; tick;
        button = 1'b1; tick;
      end
      button = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        tick;
        seen = last_p ? (stall == 1'b0) : (led_index != 2'(i));
      end
      check("press_seen", seen, 1);
      if (!last_p) begin
        check("advance_idx", led_index, i + 1);
        if (long_hold) begin
          repeat (100) tick;
          check("hold_no_repeat", led_index, i + 1);
        end
        button = 1'b0;
        repeat (8) tick;
      end else begin
        check("done_valid", led_valid, 0);
        check("done_idx", led_index, nb - 1);
        check("done_byte", led_byte, (d >> (8 * (nb - 1))) & 32'hFF);
        check("done_all_shown", q.size(), 0);
        if (chain) begin
          write_data = nd;
          bit_width  = 4'(nw);
          #1;
          check("done_no_accept", stall, 0);
          tick;
          check("chain_accept", stall, (nw != 0));
          push_word(nd, nw);
          button = 1'b0;
          tick;
          check("chain_show", led_valid, 1);
          repeat (7) tick;
        end else begin
          need_write = 1'b0;
          button = 1'b0;
          tick;
          check("idle_stall", stall, 0);
          check("idle_valid", led_valid, 0);
          repeat (7) tick;
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int nb;
    logic [31:0] d;

    // Reset with a request and the button both active
    rst_n      = 1'b0;
    need_write = 1'b1;
    write_data = 32'hA1B2C3D4;
    bit_width  = 4'd4;
    button     = 1'b1;
    repeat (3) tick;
    check("rst_stall", stall, 0);
    check("rst_valid", led_valid, 0);
    check("rst_byte", led_byte, 0);
    check("rst_index", led_index, 0);
    button = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;

    // Full word, clean presses
    start_word(32'hA1B2C3D4, 4);
    show_word(32'hA1B2C3D4, 4, 4, 0, 0, 0, 0, 0);

    // A press with no word pending is discarded
    button = 1'b1; repeat (8) tick;
    button = 1'b0; repeat (8) tick;
    check("idle_press_stall", stall, 0);
    check("idle_press_valid", led_valid, 0);

    // Bouncy first press, then a long hold
    start_word(32'h55667788, 2);
    show_word(32'h55667788, 2, 2, 0, 0, 0, 1, 1);

    // Width 0 is a no-op; width 9 clamps to 4; chained request through DONE
    start_word(32'h0BADF00D, 0);
    start_word(32'h11223344, 9);
    show_word(32'h11223344, 9, 4, 1, 32'hCAFEF00D, 3, 0, 0);
    show_word(32'hCAFEF00D, 3, 3, 0, 0, 0, 0, 0);

    // Reset in the middle of a word
    start_word(32'hDEADBEEF, 4);
    show_word(32'hDEADBEEF, 4, 2, 0, 0, 0, 0, 0);
    check("pre_mid_rst_idx", led_index, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_valid", led_valid, 0);
    check("mid_rst_index", led_index, 0);
    check("mid_rst_byte", led_byte, 0);
    q.delete();
    tick;
    tick;
    need_write = 1'b0;
    rst_n = 1'b1;
    tick;
    check("post_rst_stall", stall, 0);
    start_word(32'h0F1E2D3C, 3);
    show_word(32'h0F1E2D3C, 3, 3, 0, 0, 0, 0, 0);

    // Randomized words and widths
    for (int n = 0; n < 12; n++) begin
      w = $urandom_range(0, 15);
      d = $urandom;
      nb = (w > 4) ? 4 : w;
      start_word(d, w);
      if (w != 0) show_word(d, w, nb, 0, 0, 0, 1'($urandom_range(0, 1)), 0);
    end

    repeat (4) tick;
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
